lcd_rx: RTL and testbench
=========================

LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 E, RS, D4, D5, D6, D7  in  1 each  HD44780 4-bit write bus, asynchronous to CLK.
REQ-005 RD_ADDR  in  7  linear DDRAM read index, 0-79.
REQ-006 RD_DATA  out  8  DDRAM[RD_ADDR], registered, 1-cycle latency.
REQ-007 BYTE_STB  out  1  one-cycle pulse per completed byte; BYTE and BYTE_RS are valid with it.
REQ-008 BYTE  out  8  last completed byte.
REQ-009 BYTE_RS  out  1  RS of that byte.
REQ-010 CURSOR_ADDR  out  7  DDRAM address counter (AC).
REQ-011 FOUR_BIT, TWO_LINE, DISP_ON, CURSOR_ON, BLINK_ON  out  1 each  mode flags.
REQ-012 BUSY  out  1  clear sweep in progress.
REQ-013 OVERRUN  out  1  sticky; set when a strobe is dropped.

Function
REQ-014 E, RS and D7..D4 SHALL pass through identical 2-FF synchronisers.
REQ-015 Synchronised RS/D SHALL be latched each cycle the synchronised E is high; a nibble SHALL be accepted on the edge where a synchronised E high->low transition is detected, using the latched value.
- Data may change at the same instant E falls and is still captured correctly.
REQ-016 Eight-bit mode (FOUR_BIT=0): each accepted nibble SHALL form byte {D7..D4,4'h0} directly.
REQ-017 Four-bit mode: first nibble = byte[7:4], second = byte[3:0]; RS taken from second nibble.
REQ-018 On byte completion, command/data effect SHALL apply on the same edge; BYTE_STB SHALL be high on the following cycle.
REQ-019 Command decode (RS=0), highest set bit wins:
- 0x80-0xFF set AC=byte[6:0]; an address invalid for current line mode SHALL load 0x00.
- 0x40-0x7F CGRAM select; following data writes are discarded until the next DDRAM set.
- 0x20-0x3F FOUR_BIT=!b4, TWO_LINE=b3.
- 0x10-0x1F ignored.
- 0x08-0x0F DISP_ON=b2, CURSOR_ON=b1, BLINK_ON=b0.
- 0x04-0x07 increment = b1.
- 0x02-0x03 AC=0.
- 0x01 clear.
REQ-020 Data (RS=1): write byte to DDRAM[index(AC)], then step AC by +1 or -1.
REQ-021 Index: one-line, AC 0x00-0x4F, index=AC, wraps 0x4F<->0x00. Two-line, AC 0x00-0x27 -> index AC; AC 0x40-0x67 -> index AC-0x18; increment 0x27->0x40 and 0x67->0x00, decrement the reverse.
REQ-022 FSM states IDLE and CLEAR. Clear SHALL enter CLEAR for exactly 80 cycles writing 0x20 to index 0..79 with BUSY=1, then set AC=0 and increment=1 and return to IDLE.
REQ-023 A nibble accepted while BUSY SHALL be dropped, set OVERRUN, and leave the nibble phase unchanged.
REQ-024 A mode switch via function set SHALL reset the nibble phase to the high nibble.
REQ-025 RD_DATA SHALL reflect a write made on edge N when it is read on edge N+1.

Reset
REQ-026 RST_N low SHALL force: FOUR_BIT=0, TWO_LINE=0, DISP_ON=0, CURSOR_ON=0, BLINK_ON=0, increment=1, AC=0, nibble phase=high, BYTE_STB=0, BYTE=0, BYTE_RS=0, OVERRUN=0, synchronisers=0.
REQ-027 On RST_N release the block SHALL enter CLEAR, with BUSY=1 for 80 cycles.
REQ-028 Reset asserted mid-byte or mid-sweep SHALL discard the partial state, and the post-release sweep SHALL restart from index 0.

Verification
REQ-029 After reset sweep, strobe D=0x3 then D=0x2 (RS=0) -> FOUR_BIT=1; then nibbles 0x0, 0xF -> DISP_ON=CURSOR_ON=BLINK_ON=1.
REQ-030 Nibbles 0x0, 0x1 -> BUSY=1 for 80 cycles; every RD_DATA=0x20 afterwards; CURSOR_ADDR=0.
REQ-031 RS=1 nibbles 0x4, 0x8 -> BYTE_STB pulse with BYTE=0x48; RD_ADDR=0 reads 0x48; CURSOR_ADDR=1.
REQ-032 Send 0x28, then 0xA7, then data 0x41 -> index 39=0x41 and CURSOR_ADDR=0x40; next data 0x42 -> index 40=0x42.
REQ-033 Strobe during BUSY -> OVERRUN=1, DDRAM unchanged; RST_N pulse after a single high nibble -> FOUR_BIT=0, OVERRUN=0, BUSY sweep repeats.

Source files
------------

// File: rtl/lcd_rx.sv
// -----------------------------------------------------------------------------
// lcd_rx -- passive HD44780 write-bus receiver with a shadow DDRAM.
//
// Listens to the E/RS/D7..D4 write bus of an HD44780-style character LCD,
// rebuilds the bytes a host writes, applies the instruction set that matters
// for display contents, and keeps an 80-byte shadow of DDRAM that can be read
// back through a registered port.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   e_i, rs_i, d4_i..d7_i  LCD write bus (asynchronous to clk)
//   rd_addr_i [6:0]     linear DDRAM read index 0..79
//   rd_data_o [7:0]     DDRAM[rd_addr_i], one cycle latency
//   byte_stb_o          one-cycle pulse per completed byte
//   byte_o [7:0]        last completed byte
//   byte_rs_o           RS of that byte
//   cursor_addr_o [6:0] DDRAM address counter (AC)
//   four_bit_o, two_line_o, disp_on_o, cursor_on_o, blink_on_o  mode flags
//   busy_o              clear sweep in progress
//   overrun_o           sticky, a nibble arrived while busy and was dropped
// -----------------------------------------------------------------------------
module lcd_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       d4_i,
  input  logic       d5_i,
  input  logic       d6_i,
  input  logic       d7_i,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       byte_stb_o,
  output logic [7:0] byte_o,
  output logic       byte_rs_o,
  output logic [6:0] cursor_addr_o,
  output logic       four_bit_o,
  output logic       two_line_o,
  output logic       disp_on_o,
  output logic       cursor_on_o,
  output logic       blink_on_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam int unsigned   DEPTH    = 80;
  localparam logic [6:0]    LAST_IDX = 7'd79;
  localparam logic [7:0]    BLANK    = 8'h20;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  // Bus synchronisers, bit order {e, rs, d7, d6, d5, d4}
  logic [5:0] sync1_q, sync2_q;
  logic       e_prev_q;
  logic [4:0] lat_q;            // {rs, d7..d4} captured while E is high
  logic       phase_q;          // 0: expecting high nibble, 1: low nibble
  logic [3:0] hi_q;
  state_e     state_q;
  logic [6:0] clr_idx_q;
  logic [6:0] ac_q;
  logic       inc_q;
  logic       cgram_q;          // CGRAM selected: data writes are discarded
  logic       four_bit_q, two_line_q, disp_on_q, cursor_on_q, blink_on_q;
  logic       overrun_q, byte_stb_q, byte_rs_q;
  logic [7:0] byte_q, rd_data_q;
  logic [7:0] mem_q [DEPTH];

  logic       e_s, e_fall, busy, nib_acc;
  logic       rx_done, rx_rs;
  logic [7:0] rx_byte;
  logic [6:0] wr_idx, mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_we;

  // Two-line mode maps line 2 (AC 0x40..0x67) onto indices 40..79.
  function automatic logic [6:0] ac_to_index(input logic [6:0] ac, input logic two);
    if (two && ac >= 7'h40) return ac - 7'h18;
    return ac;
  endfunction

  function automatic logic ac_valid(input logic [6:0] ac, input logic two);
    if (two) return (ac <= 7'h27) || (ac >= 7'h40 && ac <= 7'h67);
    return ac <= 7'h4F;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic two,
                                         input logic inc);
    if (two) begin
      if (inc) begin
        if (ac == 7'h27) return 7'h40;
        if (ac == 7'h67) return 7'h00;
        return ac + 7'd1;
      end
      if (ac == 7'h40) return 7'h27;
      if (ac == 7'h00) return 7'h67;
      return ac - 7'd1;
    end
    if (inc) return (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
    return (ac == 7'h00) ? 7'h4F : ac - 7'd1;
  endfunction

  assign e_s     = sync2_q[5];
  assign e_fall  = e_prev_q & ~e_s;
  assign busy    = (state_q == ST_CLEAR);
  assign nib_acc = e_fall & ~busy;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rx_done = 1'b0;
    rx_rs   = lat_q[4];
    rx_byte = 8'h00;
    if (nib_acc) begin
      if (!four_bit_q) begin
        rx_done = 1'b1;
        rx_byte = {lat_q[3:0], 4'h0};
      end else if (phase_q) begin
        rx_done = 1'b1;
        rx_byte = {hi_q, lat_q[3:0]};
      end
    end
  end

  // Sweep and data writes never coincide: bytes cannot complete while busy.
  assign wr_idx    = ac_to_index(ac_q, two_line_q);
  assign mem_we    = busy || (rx_done && rx_rs && !cgram_q && wr_idx < 7'd80);
  assign mem_waddr = busy ? clr_idx_q : wr_idx;
  assign mem_wdata = busy ? BLANK : rx_byte;

  // NOTE: the DDRAM array has no reset; the post-reset clear sweep gives it a
  // defined content, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    rd_data_q <= (rd_addr_i < 7'd80) ? mem_q[rd_addr_i] : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      e_prev_q    <= 1'b0;
      lat_q       <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      state_q     <= ST_CLEAR;   // the block sweeps DDRAM right after reset
      clr_idx_q   <= '0;
      ac_q        <= '0;
      inc_q       <= 1'b1;
      cgram_q     <= 1'b0;
      four_bit_q  <= 1'b0;
      two_line_q  <= 1'b0;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      overrun_q   <= 1'b0;
      byte_stb_q  <= 1'b0;
      byte_q      <= '0;
      byte_rs_q   <= 1'b0;
    end else begin
      sync1_q    <= {e_i, rs_i, d7_i, d6_i, d5_i, d4_i};
      sync2_q    <= sync1_q;
      e_prev_q   <= e_s;
      // Latching while E is high means data changing together with the
      // falling E is never seen: the accepted nibble is the pre-fall value.
      if (e_s) lat_q <= sync2_q[4:0];
      byte_stb_q <= rx_done;
      if (e_fall && busy) overrun_q <= 1'b1;
      if (nib_acc && four_bit_q && !phase_q) begin
        hi_q    <= lat_q[3:0];
        phase_q <= 1'b1;
      end

      if (rx_done) begin
        byte_q    <= rx_byte;
        byte_rs_q <= rx_rs;
        phase_q   <= 1'b0;
        if (rx_rs) begin
          if (!cgram_q) ac_q <= ac_step(ac_q, two_line_q, inc_q);
        end else if (rx_byte[7]) begin
          ac_q    <= ac_valid(rx_byte[6:0], two_line_q) ? rx_byte[6:0] : 7'h00;
          cgram_q <= 1'b0;
        end else if (rx_byte[6]) begin
          cgram_q <= 1'b1;
        end else if (rx_byte[5]) begin
          four_bit_q <= ~rx_byte[4];
          two_line_q <= rx_byte[3];
          phase_q    <= 1'b0;
        end else if (rx_byte[4]) begin
          // cursor/display shift does not alter DDRAM or AC here
        end else if (rx_byte[3]) begin
          disp_on_q   <= rx_byte[2];
          cursor_on_q <= rx_byte[1];
          blink_on_q  <= rx_byte[0];
        end else if (rx_byte[2]) begin
          inc_q <= rx_byte[1];
        end else if (rx_byte[1]) begin
          ac_q <= 7'h00;
        end else if (rx_byte[0]) begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= '0;
        end
      end

      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            ac_q    <= 7'h00;
            inc_q   <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data_o     = rd_data_q;
  assign byte_stb_o    = byte_stb_q;
  assign byte_o        = byte_q;
  assign byte_rs_o     = byte_rs_q;
  assign cursor_addr_o = ac_q;
  assign four_bit_o    = four_bit_q;
  assign two_line_o    = two_line_q;
  assign disp_on_o     = disp_on_q;
  assign cursor_on_o   = cursor_on_q;
  assign blink_on_o    = blink_on_q;
  assign busy_o        = busy;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_lcd_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_rx -- self-checking bench for lcd_rx.
// A behavioural model tracks the display as a linear cursor position 0..79
// plus mode flags and an 80-byte array; a per-cycle compare process checks
// strobes, flags, AC, busy and DDRAM reads against it. Directed literal
// checks pin the model, then randomized byte streams exercise both line modes
// and 8-bit mode.
// -----------------------------------------------------------------------------
module tb_lcd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e = 1'b0, rs = 1'b0;
  logic [3:0] d = 4'h0;
  logic [6:0] rd_addr = 7'h0;
  logic [7:0] rd_data_o, byte_o;
  logic [6:0] cursor_addr_o;
  logic       byte_stb_o, byte_rs_o, four_bit_o, two_line_o, disp_on_o;
  logic       cursor_on_o, blink_on_o, busy_o, overrun_o;

  always #5 clk = ~clk;

  lcd_rx dut (
    .clk(clk), .rst_n(rst_n), .e_i(e), .rs_i(rs),
    .d4_i(d[0]), .d5_i(d[1]), .d6_i(d[2]), .d7_i(d[3]),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_o),
    .byte_stb_o(byte_stb_o), .byte_o(byte_o), .byte_rs_o(byte_rs_o),
    .cursor_addr_o(cursor_addr_o), .four_bit_o(four_bit_o),
    .two_line_o(two_line_o), .disp_on_o(disp_on_o),
    .cursor_on_o(cursor_on_o), .blink_on_o(blink_on_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_four, m_two, m_disp, m_cur, m_blk, m_inc, m_cg, m_ov, m_ph;
  logic [3:0] m_hi;
  int         m_pos, m_busy;
  logic [7:0] m_mem [80];
  logic [8:0] exp_q [$];
  bit         chk_en = 1'b0;
  logic [7:0] exp_rd;
  bit         exp_rd_ok = 1'b0;
  int         rd_force = -1;
  logic [7:0] last_byte = 8'h00;
  logic [8:0] popped;
  int         busy_run = 0, last_run = 0;

  // Line 1 holds positions 0..39 at 0x00.., line 2 positions 40..79 at 0x40..
  function automatic int pos_to_addr(input int p);
    if (m_two) return (p < 40) ? p : p + 24;
    return p;
  endfunction

  function automatic int addr_to_pos(input int a);
    if (m_two) begin
      if (a <= 39) return a;
      if (a >= 64 && a <= 103) return a - 24;
      return 0;
    end
    return (a < 80) ? a : 0;
  endfunction

  task automatic model_reset();
    {m_four, m_two, m_disp, m_cur, m_blk, m_cg, m_ov, m_ph} = '0;
    m_inc  = 1'b1;
    m_hi   = 4'h0;
    m_pos  = 0;
    m_busy = 79;   // the first post-release edge is already part of the sweep
    foreach (m_mem[i]) m_mem[i] = 8'h20;
    exp_q.delete();
    exp_rd_ok = 1'b0;
  endtask

  task automatic model_apply(input logic r, input logic [7:0] b);
    if (r) begin
      if (!m_cg) begin
        m_mem[m_pos] = b;
        m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
      end
    end else if (b[7]) begin m_pos = addr_to_pos(int'(b[6:0])); m_cg = 1'b0; end
    else if (b[6]) m_cg = 1'b1;
    else if (b[5]) begin m_four = !b[4]; m_two = b[3]; end
    else if (b[4]) ;
    else if (b[3]) {m_disp, m_cur, m_blk} = b[2:0];
    else if (b[2]) m_inc = b[1];
    else if (b[1]) m_pos = 0;
    else if (b[0]) begin m_busy = 80; foreach (m_mem[i]) m_mem[i] = 8'h20; end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (byte_stb_o) begin
        if (exp_q.size() == 0) check("stb_unexpected", byte_stb_o, 1'b0);
        else begin
          popped = exp_q.pop_front();
          check("byte", {byte_rs_o, byte_o}, popped);
          last_byte = byte_o;
          model_apply(popped[8], popped[7:0]);
        end
      end
      check("state", {busy_o, four_bit_o, two_line_o, disp_on_o, cursor_on_o,
                      blink_on_o, cursor_addr_o},
            {m_busy > 0, m_four, m_two, m_disp, m_cur, m_blk, 7'(pos_to_addr(m_pos))});
      if (exp_rd_ok) check("rd_data", rd_data_o, exp_rd);
      rd_addr   = (rd_force >= 0) ? 7'(rd_force) : 7'($urandom_range(79));
      exp_rd    = m_mem[rd_addr];
      exp_rd_ok = (m_busy == 0);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_pos = 0; m_inc = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else if (busy_o) busy_run++;
    else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 300 && (busy_o || m_busy > 0); i++) @(negedge clk);
    if (busy_o || m_busy > 0) check("idle_timeout", busy_o, 1'b0);
  endtask

  task automatic send_nibble(input logic r, input logic [3:0] v);
    @(negedge clk);
    rs = r; d = v;
    @(negedge clk);
    e = 1'b1;
    repeat (3) @(negedge clk);
    // Data changes together with the falling E; the pre-fall value must win.
    e = 1'b0; rs = 1'($urandom); d = 4'($urandom);
    if (m_busy > 0) m_ov = 1'b1;
    else if (!m_four) exp_q.push_back({r, v, 4'h0});
    else if (!m_ph) begin m_hi = v; m_ph = 1'b1; end
    else begin exp_q.push_back({r, m_hi, v}); m_ph = 1'b0; end
    repeat (6) @(negedge clk);
    check("overrun", overrun_o, m_ov);
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b);
    wait_idle();
    send_nibble(r, b[7:4]);
    send_nibble(r, b[3:0]);
  endtask

  task automatic read_at(input int a, input logic [7:0] exp, input string name);
    rd_force = a;
    repeat (3) @(negedge clk);
    check(name, rd_data_o, exp);
    rd_force = -1;
  endtask

  task automatic do_reset(input int hold, input bit full);
    int cnt;
    @(negedge clk);
    rst_n = 1'b0; chk_en = 1'b0; e = 1'b0; rs = 1'b0; d = 4'h0;
    #1;
    check("rst_flags", {four_bit_o, two_line_o, disp_on_o, cursor_on_o, blink_on_o}, 5'b0);
    check("rst_byte", {byte_stb_o, byte_rs_o, byte_o}, 10'h0);
    check("rst_overrun", overrun_o, 1'b0);
    check("rst_ac", cursor_addr_o, 7'h0);
    check("rst_busy", busy_o, 1'b1);
    repeat (hold) @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    if (!full) begin
      repeat (30) @(negedge clk);
    end else begin
      cnt = busy_o ? 1 : 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (busy_o) cnt++;
        else break;
      end
      check("sweep_len", cnt, 80);
    end
  endtask

  task automatic random_4bit(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(99);
      if (r < 60)      send_byte(1'b1, 8'($urandom));
      else if (r < 75) send_byte(1'b0, 8'h80 | 8'($urandom_range(127)));
      else if (r < 82) send_byte(1'b0, 8'h08 | 8'($urandom_range(7)));
      else if (r < 88) send_byte(1'b0, 8'h04 | 8'($urandom_range(3)));
      else if (r < 92) send_byte(1'b0, 8'h02 | 8'($urandom_range(1)));
      else if (r < 96) send_byte(1'b0, 8'h10 | 8'($urandom_range(15)));
      else             send_byte(1'b0, 8'h01);
    end
  endtask

  initial begin
    do_reset(3, 1'b1);

    // 8-bit function sets, then 4-bit mode
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h2);
    check("four_bit_on", four_bit_o, 1'b1);
    send_byte(1'b0, 8'h0F);
    check("disp_flags", {disp_on_o, cursor_on_o, blink_on_o}, 3'b111);

    // clear
    last_run = 0;
    send_byte(1'b0, 8'h01);
    wait_idle();
    repeat (2) @(negedge clk);
    check("clear_len", last_run, 80);
    check("clear_ac", cursor_addr_o, 7'h00);
    for (int i = 0; i < 80; i++) read_at(i, 8'h20, "clear_mem");

    // first data byte
    send_byte(1'b1, 8'h48);
    check("byte_48", last_byte, 8'h48);
    read_at(0, 8'h48, "mem0_48");
    check("ac_after_48", cursor_addr_o, 7'h01);

    // two-line wrap from end of line 1 to line 2
    send_byte(1'b0, 8'h28);
    send_byte(1'b0, 8'hA7);
    send_byte(1'b1, 8'h41);
    check("ac_wrap_40", cursor_addr_o, 7'h40);
    read_at(39, 8'h41, "mem39_41");
    send_byte(1'b1, 8'h42);
    read_at(40, 8'h42, "mem40_42");
    check("ac_41", cursor_addr_o, 7'h41);

    // strobe during sweep is dropped and flagged; phase is unchanged
    send_byte(1'b0, 8'h01);
    send_nibble(1'b1, 4'h5);
    check("overrun_set", overrun_o, 1'b1);
    send_byte(1'b1, 8'h33);
    check("byte_after_drop", last_byte, 8'h33);

    // CGRAM writes are discarded until a DDRAM address set
    send_byte(1'b0, 8'h40);
    send_byte(1'b1, 8'h77);
    send_byte(1'b0, 8'h80);

    random_4bit(150);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h20);   // stay 4-bit, one-line
    random_4bit(100);

    // reset in the middle of a byte
    send_nibble(1'b0, 4'h3);
    do_reset(3, 1'b1);
    check("four_bit_after_rst", four_bit_o, 1'b0);
    check("overrun_after_rst", overrun_o, 1'b0);

    // reset in the middle of the sweep restarts it in full
    do_reset(2, 1'b0);
    do_reset(2, 1'b1);

    // 8-bit mode random traffic
    for (int i = 0; i < 80; i++) begin
      logic [3:0] cmds [4];
      cmds = '{4'h0, 4'h1, 4'h3, 4'h8};
      wait_idle();
      if ($urandom_range(9) < 6) send_nibble(1'b1, 4'($urandom));
      else if ($urandom_range(1) == 1) send_nibble(1'b0, 4'h8 | 4'($urandom_range(7)));
      else send_nibble(1'b0, cmds[$urandom_range(3)]);
    end

    repeat (10) @(negedge clk);
    check("stb_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
